// File: rtl/fib_frame_stack_if.sv
// Request/response bundle between the Fibonacci controller (master) and its frame stack (slave).
interface fib_frame_stack_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PTRW  = 4
);
  logic             start;
  logic [WIDTH-1:0] nIn;
  logic             pushSig;
  logic             popSig;
  logic [WIDTH-1:0] pushN;
  logic [WIDTH-1:0] pushFlag;
  logic [WIDTH-1:0] pushRes;
  logic             readySig;
  logic [WIDTH-1:0] popN;
  logic [WIDTH-1:0] popFlag;
  logic [WIDTH-1:0] popRes;
  logic             emptySig;
  logic             fullSig;
  logic             overflow;
  logic             underflow;
  logic [PTRW:0]    count;

  modport master (
    output start, nIn, pushSig, popSig, pushN, pushFlag, pushRes,
    input  readySig, popN, popFlag, popRes, emptySig, fullSig, overflow, underflow, count
  );

  modport slave (
    input  start, nIn, pushSig, popSig, pushN, pushFlag, pushRes,
    output readySig, popN, popFlag, popRes, emptySig, fullSig, overflow, underflow, count
  );
endinterface

// File: rtl/fib_frame_stack.sv
// LIFO of {n, flag, res} call frames for the recursive Fibonacci controller.
// Each request takes one busy cycle; start clears the stack and seeds the root frame.
module fib_frame_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTRW  = 4
) (
  input  logic                clk,
  input  logic                rst,
  fib_frame_stack_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StSeed, StWrite, StRead} state_e;

  localparam logic [PTRW:0] LpDepth = (PTRW + 1)'(DEPTH);
  localparam logic [PTRW:0] LpOne   = (PTRW + 1)'(1);

  state_e                 r_state;
  logic [PTRW:0]          r_sp;
  logic                   r_ready;
  logic [WIDTH-1:0]       r_pop_n;
  logic [WIDTH-1:0]       r_pop_flag;
  logic [WIDTH-1:0]       r_pop_res;
  logic                   r_over;
  logic                   r_under;
  logic [WIDTH-1:0]       r_lat_n;
  logic [WIDTH-1:0]       r_lat_flag;
  logic [WIDTH-1:0]       r_lat_res;
  logic [3*WIDTH-1:0]     r_mem [DEPTH];

  logic                   w_full;
  logic                   w_empty;
  logic [PTRW:0]          w_sp_inc;
  logic [PTRW:0]          w_sp_dec;
  logic [3*WIDTH-1:0]     w_rd;

  assign w_full   = (r_sp == LpDepth);
  assign w_empty  = (r_sp == '0);
  assign w_sp_inc = r_sp + LpOne;
  assign w_sp_dec = r_sp - LpOne;
  assign w_rd     = r_mem[w_sp_dec[PTRW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_sp       <= '0;
      r_ready    <= 1'b1;
      r_pop_n    <= '0;
      r_pop_flag <= '0;
      r_pop_res  <= '0;
      r_over     <= 1'b0;
      r_under    <= 1'b0;
      r_lat_n    <= '0;
      r_lat_flag <= '0;
      r_lat_res  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_lat_n <= bus.nIn;
            r_state <= StSeed;
            r_ready <= 1'b0;
          end else if (bus.pushSig) begin
            r_lat_n    <= bus.pushN;
            r_lat_flag <= bus.pushFlag;
            r_lat_res  <= bus.pushRes;
            r_state    <= StWrite;
            r_ready    <= 1'b0;
          end else if (bus.popSig) begin
            r_state <= StRead;
            r_ready <= 1'b0;
          end
        end
        StSeed: begin
          r_sp    <= LpOne;
          r_over  <= 1'b0;
          r_under <= 1'b0;
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
        StWrite: begin
          if (!w_full) r_sp <= w_sp_inc;
          else         r_over <= 1'b1;
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
        StRead: begin
          if (!w_empty) begin
            r_sp       <= w_sp_dec;
            r_pop_n    <= w_rd[3*WIDTH-1:2*WIDTH];
            r_pop_flag <= w_rd[2*WIDTH-1:WIDTH];
            r_pop_res  <= w_rd[WIDTH-1:0];
          end else begin
            r_under <= 1'b1;
          end
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Memory is not reset; an async reset forces StIdle first, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (r_state == StSeed) begin
      r_mem[0] <= {r_lat_n, WIDTH'(1), WIDTH'(0)};
    end else if (r_state == StWrite && !w_full) begin
      r_mem[r_sp[PTRW-1:0]] <= {r_lat_n, r_lat_flag, r_lat_res};
    end
  end

  assign bus.readySig  = r_ready;
  assign bus.popN      = r_pop_n;
  assign bus.popFlag   = r_pop_flag;
  assign bus.popRes    = r_pop_res;
  assign bus.emptySig  = w_empty;
  assign bus.fullSig   = w_full;
  assign bus.overflow  = r_over;
  assign bus.underflow = r_under;
  assign bus.count     = r_sp;

endmodule

// File: tb/tb_fib_frame_stack.sv
// Self-checking bench for fib_frame_stack: a reference stack model feeds a pop scoreboard.
module tb_fib_frame_stack;

  logic clk;
  logic rst;

  fib_frame_stack_if #(.WIDTH(8), .PTRW(4)) bus_if ();

  fib_frame_stack #(.WIDTH(8), .DEPTH(16), .PTRW(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests;
  int unsigned n_fail;

  logic [23:0] m_stk[$];
  logic [23:0] m_last;
  logic        m_over;
  logic        m_under;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(bus_if.count), 32'(m_stk.size()));
    check({tag, ".empty"}, 32'(bus_if.emptySig), 32'(m_stk.size() == 0));
    check({tag, ".full"}, 32'(bus_if.fullSig), 32'(m_stk.size() == 16));
    check({tag, ".ovf"}, 32'(bus_if.overflow), 32'(m_over));
    check({tag, ".udf"}, 32'(bus_if.underflow), 32'(m_under));
  endtask

  task automatic wait_ready(input string tag);
    int unsigned i;
    i = 0;
    while (!bus_if.readySig && i < 8) begin
      @(posedge clk); #1;
      i++;
    end
    if (!bus_if.readySig) check({tag, ".timeout"}, 32'(bus_if.readySig), 32'd1);
  endtask

  // Drive one request for one cycle; it must cause exactly one busy cycle.
  task automatic issue(input string tag, input logic st, input logic pu, input logic po);
    bus_if.start   = st;
    bus_if.pushSig = pu;
    bus_if.popSig  = po;
    @(posedge clk); #1;
    bus_if.start   = 1'b0;
    bus_if.pushSig = 1'b0;
    bus_if.popSig  = 1'b0;
    check({tag, ".busy"}, 32'(bus_if.readySig), 32'd0);
    @(posedge clk); #1;
    check({tag, ".ready"}, 32'(bus_if.readySig), 32'd1);
    wait_ready(tag);
  endtask

  task automatic model_push(input logic [23:0] f);
    if (m_stk.size() < 16) m_stk.push_back(f);
    else m_over = 1'b1;
  endtask

  task automatic model_pop();
    if (m_stk.size() > 0) m_last = m_stk.pop_back();
    else m_under = 1'b1;
    exp_q.push_back(m_last);
  endtask

  task automatic compare_pop(input string tag);
    logic [23:0] e;
    if (exp_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".pop"}, {8'd0, bus_if.popN, bus_if.popFlag, bus_if.popRes}, {8'd0, e});
    end
  endtask

  task automatic do_start(input logic [7:0] n);
    bus_if.nIn = n;
    issue("start", 1'b1, 1'b0, 1'b0);
    m_stk.delete();
    m_stk.push_back({n, 8'd1, 8'd0});
    m_over  = 1'b0;
    m_under = 1'b0;
  endtask

  task automatic do_push(input logic [23:0] f);
    bus_if.pushN    = f[23:16];
    bus_if.pushFlag = f[15:8];
    bus_if.pushRes  = f[7:0];
    issue("push", 1'b0, 1'b1, 1'b0);
    model_push(f);
  endtask

  task automatic do_pop();
    model_pop();
    issue("pop", 1'b0, 1'b0, 1'b1);
    compare_pop("pop");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_last  = '0;
    m_over  = 1'b0;
    m_under = 1'b0;
    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.nIn = '0; bus_if.pushSig = 1'b0; bus_if.popSig = 1'b0;
    bus_if.pushN = '0; bus_if.pushFlag = '0; bus_if.pushRes = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    check("rst.ready", 32'(bus_if.readySig), 32'd1);
    check({8'd0, bus_if.popN, bus_if.popFlag, bus_if.popRes} == 32'd0 ? "rst.pop" : "rst.pop",
          {8'd0, bus_if.popN, bus_if.popFlag, bus_if.popRes}, 32'd0);
    check_state("rst");

    do_start(8'd5);
    check_state("seed5");
    do_pop();
    check_state("root_pop");

    do_push({8'd3, 8'd1, 8'd0}); @(posedge clk); #1;
    do_push({8'd2, 8'd2, 8'd7}); @(posedge clk); #1;
    do_push({8'd1, 8'd1, 8'd4});
    check_state("three");
    for (int i = 0; i < 3; i++) begin
      do_pop();
      check_state("lifo");
    end

    for (int i = 0; i < 16; i++) do_push({8'(i + 16), 8'(i), 8'(255 - i)});
    check_state("filled");
    do_push({8'hAA, 8'hBB, 8'hCC});
    check_state("ovf");
    do_pop();
    check_state("top_after_ovf");

    while (m_stk.size() > 0) do_pop();
    do_pop();
    check_state("udf");

    do_start(8'd9);
    check_state("seed9");

    do_push({8'd4, 8'd0, 8'd1});
    // push and pop together: push has priority
    bus_if.pushN = 8'd6; bus_if.pushFlag = 8'd1; bus_if.pushRes = 8'd2;
    issue("pushpop", 1'b0, 1'b1, 1'b1);
    model_push({8'd6, 8'd1, 8'd2});
    check_state("pushpop");

    // pop pulsed during the busy cycle of a push is dropped
    bus_if.pushN = 8'd7; bus_if.pushFlag = 8'd0; bus_if.pushRes = 8'd3;
    bus_if.pushSig = 1'b1;
    @(posedge clk); #1;
    bus_if.pushSig = 1'b0;
    bus_if.popSig  = 1'b1;
    @(posedge clk); #1;
    bus_if.popSig  = 1'b0;
    model_push({8'd7, 8'd0, 8'd3});
    wait_ready("ign");
    @(posedge clk); #1;
    check_state("ignored_pop");

    // reset during the WRITE cycle at count=4
    bus_if.pushN = 8'h55; bus_if.pushFlag = 8'h66; bus_if.pushRes = 8'h77;
    bus_if.pushSig = 1'b1;
    @(posedge clk); #1;
    bus_if.pushSig = 1'b0;
    rst = 1'b1;
    #1;
    m_stk.delete();
    m_over  = 1'b0;
    m_under = 1'b0;
    check("arst.ready", 32'(bus_if.readySig), 32'd1);
    check("arst.pop", {8'd0, bus_if.popN, bus_if.popFlag, bus_if.popRes}, 32'd0);
    check_state("arst");
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check_state("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
